// File: rtl/cmp_sched.sv
// cmp_sched: shares one registered comparator among NUM_REQ requesters, one request in flight; response valid CMP_LAT+1 cycles after accept.
// req_ready stays low until the response handshakes; arbitration is round-robin with CMP_SCHED_RR_EN, otherwise fixed priority.
module cmp_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int CMP_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in2,
  output logic [DATA_WIDTH-1:0]         cmp_in1,
  output logic [DATA_WIDTH-1:0]         cmp_in2,
  input  logic [DATA_WIDTH-1:0]         cmp_out,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          busy
);
  localparam int CNT_W = $clog2(CMP_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [ID_W-1:0]       cur_id;
  logic [ID_W-1:0]       win_id;
  logic                  win_vld;
  logic                  accept;
  logic                  cnt_last;
  logic [DATA_WIDTH-1:0] win_in1;
  logic [DATA_WIDTH-1:0] win_in2;

`ifdef CMP_SCHED_RR_EN
  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      off;
  logic [2*NUM_REQ-1:0] rot_src;
  logic [2*NUM_REQ-1:0] rot_sh;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W:0]        sum;

  // Rotate the request vector so the pointer position lands at bit 0,
  // then the lowest set bit is the first requester at/after the pointer.
  assign rot_src = {req_valid, req_valid};
  assign rot_sh  = rot_src >> ptr;
  assign rot     = rot_sh[NUM_REQ-1:0];

  always_comb begin
    win_vld = 1'b0;
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win_vld = 1'b1;
        off     = ID_W'(k);
      end
    end
  end

  assign sum    = {1'b0, ptr} + {1'b0, off};
  assign win_id = (sum >= NREQ) ? ID_W'(sum - NREQ) : ID_W'(sum);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(k);
      end
    end
  end
`endif

  always_comb begin
    win_in1 = '0;
    win_in2 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == ID_W'(k)) begin
        win_in1 = req_in1[k*DATA_WIDTH +: DATA_WIDTH];
        win_in2 = req_in2[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept   = (state == IDLE) && win_vld;
  assign cnt_last = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld)    state_nxt = WAIT;
      WAIT:    if (cnt_last)   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is combinational in the IDLE cycle; masked during reset so a held
  // request never sees a spurious accept while rstn is low.
  always_comb begin
    req_ready  = '0;
    if (accept && rstn) req_ready = NUM_REQ'(1) << win_id;
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_in1   <= '0;
      cmp_in2   <= '0;
      cur_id    <= '0;
      cnt       <= '0;
      resp_id   <= '0;
      resp_data <= '0;
    end else if (accept) begin
      cmp_in1 <= win_in1;
      cmp_in2 <= win_in2;
      cur_id  <= win_id;
      cnt     <= CNT_W'(CMP_LAT);
    end else if (state == WAIT) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt_last) begin
        resp_data <= cmp_out;
        resp_id   <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_cmp_sched.sv
// Bench for cmp_sched: directed scenarios then random traffic against a transaction-level model.
module tb_cmp_sched;
  localparam int DW = 16, N = 4, IW = 2, LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*DW-1:0]   req_in1, req_in2;
  logic [DW-1:0]     cmp_in1, cmp_in2, cmp_out;
  logic              resp_valid, resp_ready, busy;
  logic [IW-1:0]     resp_id;
  logic [DW-1:0]     resp_data;

  logic [N-1:0]      v3, rdy3;
  logic [N*DW-1:0]   in1_3, in2_3;
  logic [DW-1:0]     cin1_3, cin2_3, cmp_out3, rdata3;
  logic              rvalid3, busy3;
  logic [IW-1:0]     rid3;

  logic              force_en;
  logic [DW-1:0]     force_val;

  cmp_sched #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_W(IW), .CMP_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .cmp_in1(cmp_in1), .cmp_in2(cmp_in2),
    .cmp_out(cmp_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy));

  cmp_sched #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_W(IW), .CMP_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(v3), .req_ready(rdy3),
    .req_in1(in1_3), .req_in2(in2_3), .cmp_in1(cin1_3), .cmp_in2(cin2_3),
    .cmp_out(cmp_out3), .resp_valid(rvalid3), .resp_ready(1'b1),
    .resp_id(rid3), .resp_data(rdata3), .busy(busy3));

  function automatic logic [DW-1:0] cmpf(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a < b)       return {8'h01, a[7:0] ^ b[7:0]};
    else if (a == b) return 16'h0200;
    else             return {8'h04, a[15:8] + b[15:8]};
  endfunction

  always_comb cmp_out = force_en ? force_val : cmpf(cmp_in1, cmp_in2);

  // Transaction-level reference: one job in flight, aged in cycles since its acceptance.
  int          total, bad, cyc, m_last_w;
  bit          m_busy;
  int          m_age, m_ptr, m_id, m_rid;
  logic [DW-1:0] m_in1, m_in2, m_data, m_rdata;
  int          g_id[$];
  int          g_cyc[$];

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0; m_rid = 0;
    m_in1 = '0; m_in2 = '0; m_data = '0; m_rdata = '0; m_last_w = -1;
  endtask

  task automatic check_now();
    int w;
    logic [N-1:0] exp_rr;
    exp_rr = '0;
    if (rstn && !m_busy) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) exp_rr = N'(1) << w;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("resp_valid", 32'(resp_valid), 32'(m_busy && m_age >= LAT + 1));
    chk("resp_id", 32'(resp_id), 32'(m_rid));
    chk("resp_data", 32'(resp_data), 32'(m_rdata));
    chk("cmp_in1", 32'(cmp_in1), 32'(m_in1));
    chk("cmp_in2", 32'(cmp_in2), 32'(m_in2));
  endtask

  task automatic tick_chk();
    @(negedge clk);
    check_now();
  endtask

  task automatic adv();
    int w;
    m_last_w = -1;
    if (!m_busy) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_age = 1; m_id = w;
        m_in1  = req_in1[w*DW +: DW];
        m_in2  = req_in2[w*DW +: DW];
        m_data = force_en ? force_val : cmpf(m_in1, m_in2);
`ifdef CMP_SCHED_RR_EN
        m_ptr  = (w + 1) % N;
`endif
        m_last_w = w;
      end
    end else if (m_age >= LAT + 1) begin
      if (resp_ready) m_busy = 0;
    end else begin
      m_age++;
      if (m_age == LAT + 1) begin m_rid = m_id; m_rdata = m_data; end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_id, n1;
    total = 0; bad = 0; cyc = 0;
    rstn = 0; req_valid = '0; req_in1 = '0; req_in2 = '0; resp_ready = 1;
    force_en = 0; force_val = '0;
    v3 = '0; in1_3 = '0; in2_3 = '0; cmp_out3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_now();
    chk("rst_busy3", 32'(busy3), 0);
    chk("rst_rvalid3", 32'(rvalid3), 0);
    @(posedge clk); #1;
    rstn = 1;

    // All four requesting continuously
    g_id.delete(); g_cyc.delete();
    for (int i = 0; i < N; i++) begin
      req_in1[i*DW +: DW] = 16'($urandom);
      req_in2[i*DW +: DW] = 16'($urandom);
    end
    req_valid = 4'hF;
    repeat (15) begin tick_chk(); adv(); end
    req_valid = '0;
    chk("grant_count", 32'(g_id.size()), 5);
    for (int k = 0; k < g_id.size() && k < 5; k++) begin
`ifdef CMP_SCHED_RR_EN
      exp_id = k % N;
`else
      exp_id = 0;
`endif
      chk("grant_order", 32'(g_id[k]), 32'(exp_id));
      if (k > 0) chk("grant_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 3);
    end

    // Single request with echoed comparator result
    force_en = 1; force_val = 16'h00A5;
    req_in1[2*DW +: DW] = 16'h1234; req_in2[2*DW +: DW] = 16'h0042;
    req_valid = 4'b0100;
    tick_chk(); chk("single_ready", 32'(req_ready), 32'h4); adv();
    req_valid = '0;
    tick_chk(); chk("single_cmp_in1", 32'(cmp_in1), 32'h1234);
    chk("single_busy", 32'(busy), 1); chk("single_nvalid", 32'(resp_valid), 0); adv();
    tick_chk(); chk("single_valid", 32'(resp_valid), 1);
    chk("single_id", 32'(resp_id), 2); chk("single_data", 32'(resp_data), 32'h00A5); adv();
    tick_chk(); chk("single_idle", 32'(busy), 0); chk("single_done", 32'(resp_valid), 0); adv();
    force_en = 0;

    // Backpressure for 5 cycles while another requester waits
    req_in1[0 +: DW] = 16'h0F0F; req_in2[0 +: DW] = 16'h8000;
    req_valid = 4'b0001; resp_ready = 0;
    tick_chk(); adv();
    req_valid = 4'b0010;
    tick_chk(); adv();
    for (int k = 0; k < 5; k++) begin
      tick_chk();
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_id", 32'(resp_id), 0);
      chk("bp_data", 32'(resp_data), 32'h010F);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      adv();
    end
    resp_ready = 1;
    tick_chk(); adv();
    tick_chk(); chk("bp_release_idle", 32'(busy), 0); chk("bp_next", 32'(req_ready), 32'h2); adv();
    req_valid = '0;
    repeat (3) begin tick_chk(); adv(); end

    // Requester 1 raises then drops valid while the scheduler is busy
    g_id.delete(); g_cyc.delete();
    req_valid = 4'b0001;
    tick_chk(); adv();
    req_valid = 4'b0010; resp_ready = 0;
    tick_chk(); chk("drop_wait_ready", 32'(req_ready), 0); adv();
    tick_chk(); chk("drop_resp_ready", 32'(req_ready), 0); adv();
    req_valid = '0; resp_ready = 1;
    repeat (6) begin tick_chk(); adv(); end
    n1 = 0;
    foreach (g_id[k]) if (g_id[k] == 1) n1++;
    chk("drop_no_grant1", 32'(n1), 0);

    // Reset while a request is waiting for the comparator
    req_in1[2*DW +: DW] = 16'hAAAA; req_in2[2*DW +: DW] = 16'h5555;
    req_valid = 4'b0100;
    tick_chk(); adv();
    rstn = 0;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_valid", 32'(resp_valid), 0);
    chk("rst_mid_cmp_in1", 32'(cmp_in1), 0);
    chk("rst_mid_cmp_in2", 32'(cmp_in2), 0);
    chk("rst_mid_id", 32'(resp_id), 0);
    chk("rst_mid_data", 32'(resp_data), 0);
    model_reset();
    @(negedge clk); check_now();
    @(posedge clk); #1;
    rstn = 1; req_valid = 4'b1010;
    tick_chk(); chk("rst_regrant", 32'(req_ready), 32'h2); adv();
    req_valid = '0;
    repeat (5) begin tick_chk(); adv(); end

    // Latency-3 instance: only the cycle-3 comparator value is captured
    in1_3[0 +: DW] = 16'hBEEF; in2_3[0 +: DW] = 16'h0101;
    v3 = 4'b0001;
    @(negedge clk); chk("l3_ready", 32'(rdy3), 32'h1);
    @(posedge clk); #1; v3 = '0; cmp_out3 = 16'h1111;
    @(negedge clk); chk("l3_cmp_in1", 32'(cin1_3), 32'hBEEF); chk("l3_nv1", 32'(rvalid3), 0);
    @(posedge clk); #1; cmp_out3 = 16'h2222;
    @(negedge clk); chk("l3_nv2", 32'(rvalid3), 0);
    @(posedge clk); #1; cmp_out3 = 16'h3333;
    @(negedge clk); chk("l3_nv3", 32'(rvalid3), 0); chk("l3_busy", 32'(busy3), 1);
    @(posedge clk); #1; cmp_out3 = 16'h4444;
    @(negedge clk); chk("l3_valid", 32'(rvalid3), 1);
    chk("l3_data", 32'(rdata3), 32'h3333); chk("l3_id", 32'(rid3), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("l3_idle", 32'(busy3), 0);
    @(posedge clk); #1;

    // Random traffic: requesters hold until granted, random consumer stalls
    for (int c = 0; c < 600; c++) begin
      tick_chk();
      adv();
      for (int i = 0; i < N; i++) begin
        if (i == m_last_w) req_valid[i] = 1'b0;
        else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            req_in1[i*DW +: DW] = 16'($urandom);
            req_in2[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? req_in1[i*DW +: DW] : 16'($urandom);
          end
        end else if (m_busy && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0; resp_ready = 1;
    repeat (8) begin tick_chk(); adv(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
